// File: rtl/pmac_pkg.sv
// Shared definitions for the pipelined multiply-accumulate core: command
// encoding, readout FSM states and byte-count helpers.
package pmac_pkg;

  typedef enum logic [1:0] {
    OP_MAC = 2'd0,
    OP_MUL = 2'd1,
    OP_CLR = 2'd2,
    OP_RD  = 2'd3
  } op_e;

  typedef enum logic {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_e;

  function automatic int byte_count(input int acc_w);
    return acc_w / 8;
  endfunction

  // Index width that stays at least one bit for a single-byte accumulator.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pmac_serializer.sv
// Readout serializer: snapshots the accumulator into a shadow register and
// streams it LSB byte first over a valid/ready port.
module pmac_serializer
  import pmac_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ACC_W-1:0] data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_byte,
  output rd_state_e        state
);

  localparam int NB = byte_count(ACC_W);
  localparam int IW = idx_width(NB);
  localparam logic [IW-1:0] LAST = IW'(NB - 1);

  logic [NB-1:0][7:0] shadow;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_d;
  rd_state_e          state_d;

  // Valid/ready: a byte transfers on any rising edge where out_valid and
  // out_ready are both high; out_byte is held steady until that happens.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RD_IDLE;
      idx    <= '0;
      shadow <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      if (load && state == RD_IDLE) begin
        shadow <= data;
      end
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    out_valid = 1'b0;
    out_byte  = '0;
    case (state)
      RD_IDLE: begin
        if (load) begin
          state_d = RD_STREAM;
          idx_d   = '0;
        end
      end
      RD_STREAM: begin
        out_valid = 1'b1;
        out_byte  = shadow[idx];
        if (out_ready) begin
          if (idx == LAST) begin
            state_d = RD_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase
  end

endmodule

// File: rtl/pmac_core.sv
// Two-stage multiply-accumulate core: stage 1 registers the command and the
// full product, stage 2 updates the accumulator or triggers a readout.
module pmac_core
  import pmac_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              ovf,
  output logic              busy
);

  localparam int PW = 2 * DATA_W;
  localparam int M  = ACC_W - 1;

  logic             s1_valid;
  op_e              s1_op;
  logic [PW-1:0]    s1_prod;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    b_ext;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sat_val;
  logic [ACC_W:0]   sum_full;
  logic             ovf_d;
  logic             mac_ovf;
  logic             accept;
  logic             rd_load;
  logic             streaming;
  rd_state_e        rd_state;

  // Operands widened to the product width so one unsigned multiply yields
  // the exact product in both signed and unsigned modes.
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    a_ext[DATA_W-1:0] = a;
    b_ext[DATA_W-1:0] = b;
    if (SIGNED != 0) begin
      a_ext[PW-1:DATA_W] = {DATA_W{a[DATA_W-1]}};
      b_ext[PW-1:DATA_W] = {DATA_W{b[DATA_W-1]}};
    end
  end

  always_comb begin
    prod_ext = {ACC_W{(SIGNED != 0) && s1_prod[PW-1]}};
    prod_ext[PW-1:0] = s1_prod;
  end

  assign sum_full = {1'b0, acc} + {1'b0, prod_ext};

  always_comb begin
    if (SIGNED != 0) begin
      mac_ovf = (acc[M] == prod_ext[M]) && (sum_full[M] != acc[M]);
      sat_val = {acc[M], {(ACC_W - 1){~acc[M]}}};
    end else begin
      mac_ovf = sum_full[ACC_W];
      sat_val = '1;
    end
  end

  always_comb begin
    acc_d = acc;
    ovf_d = ovf;
    if (s1_valid) begin
      case (s1_op)
        OP_MAC: begin
          acc_d = sum_full[ACC_W-1:0];
          if (mac_ovf) begin
            ovf_d = 1'b1;
            if (SATURATE != 0) acc_d = sat_val;
          end
        end
        OP_MUL: acc_d = prod_ext;
        OP_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // A pending RD blocks new commands so the shadow snapshot is never raced.
  assign rd_load   = s1_valid && (s1_op == OP_RD);
  assign streaming = (rd_state == RD_STREAM);
  assign in_ready  = !(streaming || rd_load);
  assign accept    = in_valid && in_ready;
  assign busy      = s1_valid || streaming;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= OP_MAC;
      s1_prod  <= '0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op   <= op_e'(op);
        s1_prod <= a_ext * b_ext;
      end
      acc <= acc_d;
      ovf <= ovf_d;
    end
  end

  pmac_serializer #(
    .ACC_W(ACC_W)
  ) u_ser (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .data     (acc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_byte (out_byte),
    .state    (rd_state)
  );

endmodule

// File: doc/pmac_core.md
PMAC_CORE -- requirements
Module: pmac_core

Interface
REQ-001 SHALL have parameter DATA_W, default 8, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default 24, accumulator width; legal only if a multiple of 8 and >= 2*DATA_W.
REQ-003 SHALL have parameter SIGNED, default 1; 1 = two's-complement operands and accumulator, 0 = unsigned.
REQ-004 SHALL have parameter SATURATE, default 1; 1 = clamp on overflow, 0 = wrap.
REQ-005 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have ports: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have ports: in_valid  in  1  command valid; in_ready  out  1  command accepted when both high.
REQ-008 SHALL have ports: op  in  2  command: MAC=0, MUL=1, CLR=2, RD=3.
REQ-009 SHALL have ports: a, b  in  DATA_W each  operands, ignored for CLR and RD.
REQ-010 SHALL have ports: out_valid  out  1; out_ready  in  1; out_byte  out  8  readout stream, LSB byte first.
REQ-011 SHALL have ports: ovf  out  1  sticky overflow flag.
REQ-012 SHALL have ports: busy  out  1  high while any op is in the pipeline or a readout is streaming.

Function
REQ-013 SHALL run a two-stage pipeline: an op accepted at edge k registers op and a*b (full 2*DATA_W product) at edge k; stage 2 applies it at edge k+1.
REQ-014 SHALL, in stage 2, apply MAC as acc <= acc + ext(product), MUL as acc <= ext(product), CLR as acc <= 0 and ovf <= 0; ext = sign-extend if SIGNED, else zero-extend.
REQ-015 SHALL detect overflow of the ACC_W-bit MAC sum: signed = operand signs equal and result sign differs; unsigned = carry out.
REQ-016 SHALL, on overflow with SATURATE=1, clamp acc to 2^(ACC_W-1)-1 or -2^(ACC_W-1) (signed) or 2^ACC_W-1 (unsigned); with SATURATE=0, keep the wrapped sum.
REQ-017 SHALL set ovf on any overflow in either mode; it holds until CLR or reset.
REQ-018 SHALL, for RD in stage 2 at edge k+1, copy acc (including every earlier-accepted op) into a shadow register, leave acc unchanged, and assert out_valid from edge k+1.
REQ-019 SHALL use readout FSM states IDLE -> STREAM (on RD in stage 2) -> IDLE (after final byte handshake); byte index counts 0..ACC_W/8-1.
REQ-020 SHALL drive out_byte = shadow byte [index] while in STREAM; advance index only on out_valid && out_ready; hold out_byte stable otherwise.
REQ-021 SHALL drop out_valid the cycle after the last byte handshake; out_byte = 0 in IDLE.
REQ-022 SHALL drive in_ready = 0 while in STREAM or while an RD occupies stage 1; 1 otherwise.
REQ-023 SHALL accept back-to-back ops (one per cycle) while in_ready = 1, with no bubbles.
REQ-024 SHALL let ops already in the pipeline complete while in_ready is low; acc updates never disturb the shadow.

Reset
REQ-025 SHALL, on rst high at a clock edge, clear acc, shadow, ovf, pipeline valid, and byte index, and set FSM to IDLE; outputs after that edge: in_ready=1, out_valid=0, out_byte=0, ovf=0, busy=0.
REQ-026 SHALL, on reset mid-stream or mid-pipeline, discard in-flight ops and the partial readout with no further out_valid.

Structure
REQ-027 SHALL keep the op encoding enum and the byte-count constant function in shared package pmac_pkg.
REQ-028 SHALL implement the readout as sub-module pmac_serializer (shadow load, FSM, byte index, valid/ready).

Verification (DATA_W=8, ACC_W=24 unless stated)
REQ-029 SHALL cover: reset asserted mid-stream -> next cycle out_valid=0, in_ready=1, ovf=0; subsequent RD streams 00,00,00.
REQ-030 SHALL cover: SIGNED=1, MAC 3*4, MAC (-5)*6 back-to-back, RD -> bytes EE,FF,FF (acc = -18), ovf=0.
REQ-031 SHALL cover: SIGNED=1, SATURATE=1, CLR then 512x MAC (-128)*(-128) -> RD bytes FF,FF,7F, ovf=1; with SATURATE=0 -> bytes 00,00,80, ovf=1.
REQ-032 SHALL cover: SIGNED=0, MUL 255*255, RD -> bytes 01,FE,00; then CLR, RD -> 00,00,00, ovf=0.
REQ-033 SHALL cover: out_ready held low 3 cycles on byte 1 -> out_byte stable for those cycles, in_ready=0 throughout the stream; MAC issued in the same cycle as the final handshake is accepted the next cycle.
REQ-034 SHALL cover: MAC 2*2 accepted the cycle before RD -> streamed value includes it (04,00,00), and a MAC 1*1 in the pipeline during the stream -> shadow unchanged, next RD gives 05,00,00.
